mul_repeat_add: RTL
===================

Name: mul_repeat_add

Overview:
- Parametrised sequential unsigned multiplier that computes a*b by repeated addition, with the datapath and control FSM combined in one block.
- Next generation of the team's repeated-addition multiplier:
  - operand width set by a parameter;
  - ready/start/done handshake;
  - returns to idle after each result instead of parking in the done state;
  - zero-operand early exit;
  - optional operand swap to minimise the number of iterations.
- Used as a small, area-cheap multiply engine in datapath/controlpath teaching designs.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32).
- PROD_W, 2*WIDTH, product width. Localparam, not overridable.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a multiply. Sampled only when ready=1.
- a_in, input, WIDTH, multiplicand. Sampled on the accepting edge.
- b_in, input, WIDTH, multiplier (iteration count). Sampled on the accepting edge.
- ready, output, 1, high in IDLE: block can accept start.
- busy, output, 1, high in RUN.
- done, output, 1, single-cycle pulse in DONE: product is valid.
- product, output, PROD_W, result register. Holds its value until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; A, B and product cleared to 0;
  - ready=1, busy=0, done=0.
  - Reset asserted mid-operation aborts it immediately. No done pulse is issued for the aborted operation.
- Registers: A (WIDTH), B (WIDTH, down-counter), product (PROD_W accumulator).
- Outputs are decoded from state only (Moore): ready=(IDLE), busy=(RUN), done=(DONE).
- State IDLE:
  - If start=1, at that edge: A<=a_in, B<=b_in, product<=0, go to RUN.
  - Otherwise stay in IDLE; product is held.
- State RUN:
  - If A==0 or B==0: go to DONE. No add is performed; product stays 0.
  - Else: product<=product+zero-extended A, B<=B-1.
  - If B==1 in that same cycle, go to DONE; otherwise stay in RUN.
- State DONE:
  - done=1 for exactly one cycle, then go to IDLE unconditionally.
  - A start asserted during DONE is ignored. It must still be high in IDLE to be accepted.
- start is ignored while in RUN or DONE, and a_in/b_in are don't-care there.
- Latency, counted from the accepting edge to the first cycle with done=1:
  - N+1 cycles, where N = b_in, or N = 1 if either operand is 0.
  - Back-to-back throughput: one op per N+2 cycles (includes the IDLE accept cycle).
- Arithmetic:
  - Unsigned only.
  - PROD_W = 2*WIDTH, so no overflow is possible: max (2^W-1)^2 < 2^(2W).
  - Adder width is PROD_W.
- Any illegal state encoding goes to IDLE on the next clock.

Optional Feature:
- Macro: MUL_MIN_ITER_EN.
- Defined: at accept, if a_in < b_in, load A<=b_in and B<=a_in; otherwise load as normal.
  - Latency becomes min(a_in,b_in)+1. The zero rule still applies: N=1 if either operand is 0.
  - Adds one WIDTH-bit comparator and two 2:1 muxes on the load path.
- Undefined: operands are loaded as given and latency follows b_in. No comparator is instantiated.
- The product value is identical in both builds.

Decomposition:
- Package mul_pkg holds:
  - the state typedef, an enum of IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - the default WIDTH constant.
- Sub-module mul_ra_ctrl: the FSM only.
  - Inputs: start, a_zero, b_zero, b_one.
  - Outputs: ld, add_dec, ready, busy, done.
- The datapath (A/B/product registers, adder, decrementer, optional swap) stays in mul_repeat_add.

Test Plan:
- WIDTH=8, a=5, b=3, start pulsed in IDLE -> busy for 3 cycles, done on cycle 4 after the accept edge, product=15. Product still 15 ten cycles later.
- a=0, b=200, then a=77, b=0 -> each finishes with one RUN cycle, done at +2, product=0. Check no add occurs (product never nonzero).
- a=255, b=255 -> done at +256, product=65025 (16'hFE01). No overflow.
- Accept a=9, b=4, then hold start high through RUN/DONE with different a_in/b_in -> product=36 and exactly one done pulse. A new op is accepted only in the following IDLE cycle.
- Accept a=10, b=50, assert rst_n low after 20 cycles -> immediate IDLE: ready=1, product=0, no done pulse. Next op a=2, b=3 gives 6.
- With MUL_MIN_ITER_EN defined: a=3, b=200 -> done at +4, product=600. Without the macro -> done at +201, product=600.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and defaults for the repeated-addition multiplier.
package mul_pkg;

    localparam int unsigned MUL_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mul_ra_ctrl.sv
// Control FSM for mul_repeat_add: IDLE -> RUN -> DONE -> IDLE, Moore-decoded status outputs.
module mul_ra_ctrl
    import mul_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic a_zero,
    input  logic b_zero,
    input  logic b_one,
    output logic ld,
    output logic add_dec,
    output logic ready,
    output logic busy,
    output logic done
);

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        ld      = 1'b0;
        add_dec = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ld      = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // A zero operand finishes in one RUN cycle without touching the accumulator.
                if (a_zero || b_zero) begin
                    state_d = DONE;
                end else begin
                    add_dec = 1'b1;
                    state_d = b_one ? DONE : RUN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: rtl/mul_repeat_add.sv
// Unsigned multiplier by repeated addition with ready/start/done handshake.
// Define MUL_MIN_ITER_EN to swap operands at accept so the smaller one sets the iteration count.
module mul_repeat_add
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PROD_W = 2 * WIDTH;

    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]  a_ld, b_ld;
    logic              ld, add_dec;
    logic              a_zero, b_zero, b_one;

`ifdef MUL_MIN_ITER_EN
    logic swap;
    assign swap = (a_in < b_in);
    assign a_ld = swap ? b_in : a_in;
    assign b_ld = swap ? a_in : b_in;
`else
    assign a_ld = a_in;
    assign b_ld = b_in;
`endif

    assign a_zero = (a_q == '0);
    assign b_zero = (b_q == '0);
    assign b_one  = (b_q == WIDTH'(1));

    mul_ra_ctrl u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_zero  (a_zero),
        .b_zero  (b_zero),
        .b_one   (b_one),
        .ld      (ld),
        .add_dec (add_dec),
        .ready   (ready),
        .busy    (busy),
        .done    (done)
    );

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        if (ld) begin
            a_d    = a_ld;
            b_d    = b_ld;
            prod_d = '0;
        end else if (add_dec) begin
            prod_d = prod_q + {{WIDTH{1'b0}}, a_q};
            b_d    = b_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
        end
    end

    assign product = prod_q;

endmodule
